// File: rtl/seg_src_arbiter.sv
// seg_src_arbiter: round-robin time-share of the 7-seg display between three sources with a minimum dwell.
// Define SEG_SRC_IDLE_BLANK_EN to blank the display while idle instead of freezing the last reading.
module seg_src_arbiter #(
  parameter logic [25:0] HOLD_MAX = 26'd49_999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic [19:0] data_0,
  input  logic [19:0] data_1,
  input  logic [19:0] data_2,
  input  logic [5:0]  point_0,
  input  logic [5:0]  point_1,
  input  logic [5:0]  point_2,
  input  logic        sign_0,
  input  logic        sign_1,
  input  logic        sign_2,
  output logic [2:0]  gnt,
  output logic [1:0]  src,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en
);
`ifdef SEG_SRC_IDLE_BLANK_EN
  localparam logic KEEP = 1'b0;
`else
  localparam logic KEEP = 1'b1;
`endif
  typedef enum logic {IDLE, SHOW} state_t;
  state_t      state, state_n;
  logic [25:0] hold_cnt, hold_n;
  logic [1:0]  last, last_n, src_n, c1, c2, win;
  logic [2:0]  gnt_n;
  logic [19:0] data_n;
  logic [5:0]  point_n;
  logic        sign_n, seg_en_n;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  // Search order last+1, last+2, last: the current holder only wins when nobody else asks.
  always_comb begin
    c1 = nxt(last);
    c2 = nxt(c1);
    win = req[c1] ? c1 : req[c2] ? c2 : last;
    state_n = state;
    hold_n = state == SHOW ? hold_cnt + 26'd1 : hold_cnt;
    last_n = last;
    gnt_n = gnt;
    src_n = src;
    if (state == IDLE || hold_cnt == HOLD_MAX || !req[src]) begin
      if (|req) begin
        state_n = SHOW;
        gnt_n = 3'b001 << win;
        src_n = win;
        last_n = win;
        hold_n = '0;
      end else if (state == SHOW) begin
        state_n = IDLE;
        gnt_n = '0;
        hold_n = '0;
      end
    end
  end
  always_comb begin
    data_n = gnt[0] ? data_0 : gnt[1] ? data_1 : gnt[2] ? data_2 : KEEP ? data : '0;
    point_n = gnt[0] ? point_0 : gnt[1] ? point_1 : gnt[2] ? point_2 : KEEP ? point : '0;
    sign_n = gnt[0] ? sign_0 : gnt[1] ? sign_1 : gnt[2] ? sign_2 : KEEP & sign;
    seg_en_n = |gnt | (KEEP & seg_en);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      hold_cnt <= '0;
      last <= 2'd2;
      gnt <= '0;
      src <= '0;
      data <= '0;
      point <= '0;
      sign <= 1'b0;
      seg_en <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      last <= last_n;
      gnt <= gnt_n;
      src <= src_n;
      data <= data_n;
      point <= point_n;
      sign <= sign_n;
      seg_en <= seg_en_n;
    end
  end
endmodule

// File: tb/tb_seg_src_arbiter.sv
// tb_seg_src_arbiter: table-driven grant checks plus a display scoreboard for seg_src_arbiter.
module tb_seg_src_arbiter;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic [2:0]  req = '0;
  logic [19:0] data_0 = 20'd1, data_1 = 20'd2, data_2 = 20'd3;
  logic [5:0]  point_0 = 6'h01, point_1 = 6'h02, point_2 = 6'h24;
  logic        sign_0 = 1'b0, sign_1 = 1'b0, sign_2 = 1'b1;
  logic [2:0]  gnt;
  logic [1:0]  src;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign, seg_en;
  int total = 0, bad = 0;
  seg_src_arbiter #(.HOLD_MAX(26'd4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .point_0(point_0), .point_1(point_1), .point_2(point_2),
    .sign_0(sign_0), .sign_1(sign_1), .sign_2(sign_2),
    .gnt(gnt), .src(src), .data(data), .point(point), .sign(sign), .seg_en(seg_en)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [19:0] d1;
    int          n;
    logic [2:0]  gnt;
  } vec_t;
  vec_t tbl[$];
  logic [27:0] sb[$];
  function automatic vec_t mk(logic r, logic [2:0] q, logic [19:0] d, int n, logic [2:0] g);
    vec_t v;
    v.rst = r; v.req = q; v.d1 = d; v.n = n; v.gnt = g;
    return v;
  endfunction
  task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
    end
  endtask
  function automatic logic [27:0] model(logic [2:0] g, logic [27:0] prev);
    if (g[0]) return {data_0, point_0, sign_0, 1'b1};
    if (g[1]) return {data_1, point_1, sign_1, 1'b1};
    if (g[2]) return {data_2, point_2, sign_2, 1'b1};
`ifdef SEG_SRC_IDLE_BLANK_EN
    return '0;
`else
    return prev;
`endif
  endfunction
  initial begin
    logic [2:0]  pgnt = '0, g0;
    logic [1:0]  esrc = '0;
    logic [27:0] pdisp = '0, want;
    int cnt;
    tbl.push_back(mk(1, 3'b111, 20'd2, 2, 3'b000));
    tbl.push_back(mk(0, 3'b111, 20'd2, 5, 3'b001));
    tbl.push_back(mk(0, 3'b111, 20'd2, 5, 3'b010));
    tbl.push_back(mk(0, 3'b111, 20'd2, 5, 3'b100));
    tbl.push_back(mk(0, 3'b111, 20'd2, 5, 3'b001));
    tbl.push_back(mk(0, 3'b010, 20'd2, 10, 3'b010));
    tbl.push_back(mk(0, 3'b010, 20'd7, 10, 3'b010));
    tbl.push_back(mk(0, 3'b001, 20'd7, 1, 3'b001));
    tbl.push_back(mk(0, 3'b101, 20'd7, 1, 3'b001));
    tbl.push_back(mk(0, 3'b100, 20'd7, 1, 3'b100));
    tbl.push_back(mk(0, 3'b001, 20'd7, 2, 3'b001));
    tbl.push_back(mk(0, 3'b101, 20'd7, 3, 3'b001));
    tbl.push_back(mk(0, 3'b101, 20'd7, 1, 3'b100));
    tbl.push_back(mk(0, 3'b000, 20'd7, 3, 3'b000));
    tbl.push_back(mk(0, 3'b100, 20'd7, 1, 3'b100));
    tbl.push_back(mk(0, 3'b111, 20'd7, 2, 3'b100));
    tbl.push_back(mk(1, 3'b111, 20'd7, 1, 3'b000));
    tbl.push_back(mk(0, 3'b111, 20'd7, 1, 3'b001));
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        sys_rst = tbl[i].rst;
        req = tbl[i].req;
        data_1 = tbl[i].d1;
        pdisp = tbl[i].rst ? 28'd0 : model(pgnt, pdisp);
        sb.push_back(pdisp);
        @(posedge sys_clk);
        #1;
        esrc = tbl[i].rst ? 2'd0 : tbl[i].gnt[0] ? 2'd0 : tbl[i].gnt[1] ? 2'd1 : tbl[i].gnt[2] ? 2'd2 : esrc;
        check("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
        check("src", i, 32'(src), 32'(esrc));
        want = sb.pop_front();
        check("disp", i, 32'({data, point, sign, seg_en}), 32'(want));
        pgnt = tbl[i].gnt;
      end
    end
    req = 3'b111;
    for (int s = 0; s < 2; s++) begin
      g0 = gnt;
      cnt = 0;
      do begin
        @(posedge sys_clk);
        #1;
        cnt++;
      end while (gnt == g0 && cnt < 20);
      check("dwell", s, 32'(cnt), 32'd5);
      check("rotate", s, 32'(gnt), s == 0 ? 32'h2 : 32'h4);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_src_arbiter.md
# seg_src_arbiter

Time-shares the six-digit seven-segment display between three independent data sources (counters, sensors, clocks) that each present a 20-bit value, decimal-point mask and sign. Round-robin arbiter with a minimum display hold time: each requesting source is shown for `HOLD_MAX+1` cycles before the display rotates to the next requester. Sits between the data generators and the display/segment-scan driver, replacing a direct generator-to-driver connection.

## Interface
- `HOLD_MAX`, 26'd49_999_999: dwell per source minus one, in clock cycles (1 s at 50 MHz).
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `req`  in  3  per-source display request, bit i = source i.
- `data_0`, `data_1`, `data_2`  in  20  value to display per source.
- `point_0`, `point_1`, `point_2`  in  6  decimal-point mask per source.
- `sign_0`, `sign_1`, `sign_2`  in  1  sign per source, 1 = show minus.
- `gnt`  out  3  one-hot grant, 0 when idle.
- `src`  out  2  index of granted source, holds last value when idle.
- `data`  out  20  value to display driver.
- `point`  out  6  decimal-point mask to display driver.
- `sign`  out  1  sign to display driver.
- `seg_en`  out  1  display enable.

## Operation
- States: IDLE, SHOW. Reset → IDLE; `hold_cnt`=0, `last`=2 (first search order 0,1,2).
- Reset values: `gnt`=3'b000, `src`=2'd0, `data`=20'd0, `point`=6'd0, `sign`=0, `seg_en`=0.
- Round-robin search: candidates checked in order `last+1`, `last+2`, `last+3` (mod 3); first with `req` set wins.
- IDLE: if `req`≠0, grant search winner, `last`←winner, `hold_cnt`←0, → SHOW. Else stay.
- SHOW, each cycle, `hold_cnt` +1. Switch event when `hold_cnt`==`HOLD_MAX` or `req[src]`==0:
  - other source requesting → grant search winner (excludes current by order), `hold_cnt`←0.
  - only current still requesting → keep grant, `hold_cnt`←0 (no gap).
  - none requesting → `gnt`←0, → IDLE.
- Requester dropping `req` mid-dwell ends its slot immediately (same switch rules).
- New requests never pre-empt a live slot before `HOLD_MAX`.
- `hold_cnt` never exceeds `HOLD_MAX`; 26-bit, no wrap.
- Display outputs registered every cycle from inputs of the source indicated by `gnt` (live tracking, not snapshot). `seg_en`=1 whenever `gnt`≠0.

## Timing
- `req` sampled at edge k in IDLE → `gnt`/`src` valid after edge k.
- `data`/`point`/`sign`/`seg_en` follow `gnt` one cycle later (edge k+1); source-input changes appear at outputs one cycle after they occur.
- Continuous requesting: grant changes exactly every `HOLD_MAX+1` cycles.
- Reset asserted mid-slot: all outputs return to reset values at that edge, arbitration restarts with source 0 priority.

## Configuration
- `SEG_SRC_IDLE_BLANK_EN` defined: in IDLE, display outputs forced to reset values (`seg_en`=0, `data`=0, `point`=0, `sign`=0) one cycle after `gnt` drops.
- Not defined: in IDLE, `data`/`point`/`sign` hold last displayed value and `seg_en` stays 1 once any source has been shown since reset (frozen last reading).

## Test plan
- `HOLD_MAX`=4; `req`=3'b111, `data_0`=1, `data_1`=2, `data_2`=3 → `src` 0,1,2,0 each for 5 cycles; `data` follows one cycle behind.
- Only `req[1]` held high for 20 cycles → `gnt`=3'b010 throughout, no gap, `data`=`data_1` continuously.
- `req[0]` high, dropped at cycle 2 of its slot while `req[2]` high → `gnt`=3'b100 on next edge, not waiting for dwell end.
- `req[2]` asserted mid-slot of source 0 → no change until source 0 completes 5 cycles, then `src`=2.
- All `req` dropped → `gnt`=0 next edge; with macro `seg_en`=0 one cycle later, without macro `data` holds last value and `seg_en`=1.
- `sys_rst` pulsed mid-slot of source 2 with `req`=3'b111 → outputs at reset values, next grant `src`=0.
